output_port_arbiter: RTL and testbench
======================================

Name: output_port_arbiter

Overview:
- Per-output-port scheduler in the 2D-mesh router. Shares one output port among NUM_PORTS input FIFOs (N, E, W, S, Local) with round-robin arbitration and wormhole locking.
- Pops the winning FIFO only when the downstream ready_in allows.
- Drives the crossbar-side data and enable into the output-port register stage.
- One instance per output port.

Parameters:
- NUM_PORTS, 5, number of requesting input ports; index 0 is Local.
- DATA_WIDTH, 32, flit width in bits (including parity).
- PTR_W, 3, width of the round-robin pointer; must satisfy 2**PTR_W >= NUM_PORTS.
- TIMEOUT_CYCLES, 256, stall limit; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_PORTS  FIFO i is non-empty and its front flit targets this output.
- head  in  NUM_PORTS  front flit of FIFO i is a header flit.
- tail  in  NUM_PORTS  front flit of FIFO i is a tail flit; head=tail=1 means a single-flit packet.
- flit_in  in  NUM_PORTS*DATA_WIDTH  front flits; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ready_in  in  1  downstream router or NI can accept a flit this cycle.
- grant  out  NUM_PORTS  one-hot registered owner of the output; all zero when idle.
- fifo_rd  out  NUM_PORTS  combinational pop strobe to FIFO i.
- data_out  out  DATA_WIDTH  combinational mux of the granted port's flit_in; zero when no grant.
- valid_out  out  1  a flit transfers this cycle; equals OR of fifo_rd.
- busy  out  1  registered; 1 in state LOCKED.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, grant=0, busy=0, rr_ptr=NUM_PORTS-1, so port 0 has first priority after reset.
  - Combinational outputs follow to fifo_rd=0, data_out=0, valid_out=0.
- Reset asserted mid-packet: lock dropped immediately, no pop. Recovery of the upstream FIFO is the caller's concern.
- FSM has two states, IDLE and LOCKED.
- IDLE:
  - Eligible ports are those with req[i] & head[i]. A req without head is ignored; it is no error in IDLE.
  - Winner = first eligible index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS.
  - If a winner exists, at the next edge: grant=onehot(winner), rr_ptr=winner, state=LOCKED, busy=1.
  - No pop occurs in IDLE. Arbitration latency is 1 cycle.
- LOCKED:
  - fifo_rd[i] = grant[i] & req[i] & ready_in.
  - data_out = flit_in[granted], whether or not it transfers.
  - valid_out = |fifo_rd.
  - Transfer with tail[granted]=1: at the next edge grant=0, state=IDLE, busy=0.
  - Transfer without tail: stay LOCKED.
  - ready_in=0, or the granted req drops mid-packet: hold grant, no pop, no state change. Wormhole hold has no timeout in the base build.
  - Requests from other ports are ignored until the owner's tail transfers.
- Packet throughput:
  - A packet of F flits with ready_in held at 1 occupies 1 + F cycles: one arbitration cycle, then one flit per cycle.
  - At least one IDLE cycle separates consecutive packets.
- rr_ptr changes only on a new grant, so every eligible port is served within NUM_PORTS packets.
- At most one bit of grant, and therefore of fifo_rd, is ever set.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - Adds output timeout_err (out, 1).
  - Adds a stall counter, clog2(TIMEOUT_CYCLES)+1 bits.
  - Counter clears on reset, in IDLE and on any transfer. It increments each LOCKED cycle without a transfer and saturates.
  - When the counter reaches TIMEOUT_CYCLES, timeout_err is set. It is sticky until reset.
  - The grant is not broken; the flag only reports the stall.
- When undefined: no port, no counter, behaviour exactly as above.

Test Plan:
- Reset release, then port 2 presents a 3-flit packet (head, body, tail: 0xA1, 0xA2, 0xA3) with ready_in=1:
  - cycle 1: grant=00100;
  - cycles 2-4: fifo_rd[2]=1, data_out 0xA1, 0xA2, 0xA3;
  - cycle 5: grant=0, busy=0.
- Ports 0, 1 and 3 each request with head, single-flit packets, held continuously:
  - grants in order 0, 1, 3, 0, each separated by one IDLE cycle;
  - never two grant bits set at once.
- Port 4 locked mid-packet, ready_in=0 for 10 cycles, port 1 requests with head:
  - grant stays 10000, fifo_rd=0, valid_out=0, data_out = port 4's flit;
  - on ready_in=1 transfer resumes, and port 1 is granted only after port 4's tail.
- Port 1 presents head=tail=1 (0x55):
  - grant at cycle 1, single pop at cycle 2 with data_out=0x55, IDLE at cycle 3.
- Port 0 has req=1 but head=0 in IDLE:
  - no grant for 5 cycles.
- Locked on port 3 after 1 of 4 flits, assert rst=0 asynchronously between edges:
  - grant, fifo_rd and busy go 0 immediately.
  - After release with ports 3 and 0 both requesting with head, port 0 wins.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8:
  - locked with ready_in=0 for 8 cycles gives timeout_err=1;
  - the flag stays 1 after transfers resume and clears only on reset.

Source files
------------

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin, wormhole-locking scheduler sharing one router output among NUM_PORTS input FIFOs.
// Optional macro ARB_TIMEOUT_EN adds a sticky stall flag (timeout_err) raised after TIMEOUT_CYCLES stalled LOCKED cycles.
module output_port_arbiter #(
    parameter int NUM_PORTS      = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int PTR_W          = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            head,
    input  logic [NUM_PORTS-1:0]            tail,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] flit_in,
    input  logic                            ready_in,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [NUM_PORTS-1:0]            fifo_rd,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            valid_out,
    output logic                            busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                            timeout_err
`endif
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_found;
    logic [NUM_PORTS-1:0] elig;
    logic                 tail_xfer;

    // Only a header flit may open a new wormhole; body flits at a FIFO front are ignored while idle.
    assign elig = req & head;

    // Round-robin search starting just after the last winner; scanning backwards leaves the nearest candidate.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_PORTS;
            if (elig[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    // Pop strobe: grant is all-zero outside LOCKED, so this is inherently gated by the lock.
    assign fifo_rd   = grant & req & {NUM_PORTS{ready_in}};
    assign valid_out = |fifo_rd;
    assign tail_xfer = |(fifo_rd & tail);

    // Crossbar mux of the owner's front flit; zero when nobody holds the output.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (grant[i]) data_out = data_out | flit_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Arbitration/lock FSM with registered grant and busy; rr_ptr moves only on a new grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= PTR_W'(NUM_PORTS - 1);
        end else if (state == IDLE) begin
            if (win_found) begin
                state  <= LOCKED;
                grant  <= NUM_PORTS'(1) << win_idx;
                busy   <= 1'b1;
                rr_ptr <= win_idx;
            end
        end else if (tail_xfer) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] stall_nxt;

    // Stall count: cleared while idle or on any transfer, otherwise counts up and saturates at the limit.
    always_comb
        stall_nxt = (state == IDLE || valid_out) ? '0 :
                    (stall_cnt == CNT_W'(TIMEOUT_CYCLES)) ? stall_cnt : stall_cnt + CNT_W'(1);

    // Sticky report of a wormhole stalled too long; the grant itself is never broken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            stall_cnt <= stall_nxt;
            if (stall_nxt == CNT_W'(TIMEOUT_CYCLES)) timeout_err <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: randomized and directed checking of output_port_arbiter against a packet-level model.
module tb_output_port_arbiter;
    localparam int N  = 5;
    localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0, head = '0, tail = '0;
    logic [N*DW-1:0] flit_in = '0;
    logic            ready_in = 1'b0;
    logic [N-1:0]    grant, fifo_rd;
    logic [DW-1:0]   data_out;
    logic            valid_out, busy;
`ifdef ARB_TIMEOUT_EN
    logic            timeout_err;
`endif

    output_port_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .PTR_W(3), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .head(head), .tail(tail), .flit_in(flit_in),
        .ready_in(ready_in), .grant(grant), .fifo_rd(fifo_rd), .data_out(data_out),
        .valid_out(valid_out), .busy(busy)
`ifdef ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int rdy_mode = 1;
    bit gap_en = 1'b0;

    // Upstream FIFOs: each entry is {head, tail, data}.
    logic [DW+1:0] q[N][$];

    // Packet-level model: which port owns the output and which port won last.
    int owner = -1;
    int last = N - 1;
    int cand;
    bit found;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive();
        logic [DW+1:0] e;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && !(gap_en && $urandom_range(0, 4) == 0)) begin
                e = q[i][0];
                req[i] = 1'b1;
                head[i] = e[DW+1];
                tail[i] = e[DW];
                flit_in[i*DW +: DW] = e[DW-1:0];
            end else begin
                req[i] = 1'b0;
                head[i] = 1'($urandom_range(0, 1));
                tail[i] = 1'($urandom_range(0, 1));
                flit_in[i*DW +: DW] = $urandom;
            end
        end
        ready_in = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    endtask

    task automatic push(int p, int n, logic [31:0] base);
        for (int k = 0; k < n; k++) q[p].push_back({k == 0, k == n - 1, base + 32'(k)});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        drive();
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic lock_on(int p, logic [31:0] base);
        do_reset();
        rdy_mode = 1;
        push(p, 4, base);
        drive();
        tick();
        chk("lock_grant", 64'(grant), 64'(N'(1) << p));
        tick();
        rdy_mode = 0;
        drive();
    endtask

    // Model update on each edge: arbitrate when free, otherwise advance the owner's packet.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner = -1;
            last = N - 1;
        end else if (owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                cand = (last + k) % N;
                if (!found && req[cand] && head[cand]) begin
                    found = 1'b1;
                    owner = cand;
                    last = cand;
                end
            end
        end else if (req[owner] && ready_in) begin
            void'(q[owner].pop_front());
            if (tail[owner]) owner = -1;
        end
    end

    // Input driver refreshes FIFO fronts just after each edge.
    always begin
        @(posedge clk);
        #1;
        drive();
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [N-1:0] eg, er;
        logic [DW-1:0] ed;
        eg = '0;
        er = '0;
        ed = '0;
        if (owner >= 0) begin
            eg = N'(1) << owner;
            ed = flit_in[owner*DW +: DW];
            if (req[owner] && ready_in) er = eg;
        end
        chk("grant", 64'(grant), 64'(eg));
        chk("fifo_rd", 64'(fifo_rd), 64'(er));
        chk("data_out", 64'(data_out), 64'(ed));
        chk("valid_out", 64'(valid_out), 64'(er != 0));
        chk("busy", 64'(busy), 64'(owner >= 0));
        chk("onehot", 64'($onehot0(grant)), 64'(1));
    end

    initial begin
        int seq[$];
        logic [N-1:0] prev;
        int t;
        drive();
        do_reset();
        chk("rst_grant", 64'(grant), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_fifo_rd", 64'(fifo_rd), 0);
        chk("rst_data", 64'(data_out), 0);
        chk("rst_valid", 64'(valid_out), 0);

        // Three-flit packet on port 2.
        push(2, 3, 32'hA1);
        drive();
        tick();
        chk("p2_grant", 64'(grant), 64'h04);
        chk("p2_rd1", 64'(fifo_rd), 64'h04);
        chk("p2_d1", 64'(data_out), 64'hA1);
        tick();
        chk("p2_d2", 64'(data_out), 64'hA2);
        tick();
        chk("p2_d3", 64'(data_out), 64'hA3);
        chk("p2_v3", 64'(valid_out), 1);
        tick();
        chk("p2_done_grant", 64'(grant), 0);
        chk("p2_done_busy", 64'(busy), 0);

        // Round robin among ports 0, 1, 3 with single-flit packets.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push(0, 1, 32'h100 + 32'(r));
            push(1, 1, 32'h110 + 32'(r));
            push(3, 1, 32'h130 + 32'(r));
        end
        drive();
        prev = '0;
        t = 0;
        while (t < 30 && seq.size() < 4) begin
            tick();
            if (grant != 0 && prev == 0)
                for (int i = 0; i < N; i++) if (grant[i]) seq.push_back(i);
            prev = grant;
            t++;
        end
        chk("rr_count", 64'(seq.size()), 4);
        if (seq.size() == 4) begin
            chk("rr_0", 64'(seq[0]), 0);
            chk("rr_1", 64'(seq[1]), 1);
            chk("rr_2", 64'(seq[2]), 3);
            chk("rr_3", 64'(seq[3]), 0);
        end

        // Stalled wormhole on port 4 while port 1 waits.
        lock_on(4, 32'h40);
        push(1, 1, 32'h10);
        drive();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_grant", 64'(grant), 64'h10);
            chk("stall_rd", 64'(fifo_rd), 0);
            chk("stall_valid", 64'(valid_out), 0);
            chk("stall_data", 64'(data_out), 64'h41);
        end
        rdy_mode = 1;
        drive();
        tick();
        chk("resume_d2", 64'(data_out), 64'h42);
        tick();
        chk("resume_d3", 64'(data_out), 64'h43);
        chk("resume_grant", 64'(grant), 64'h10);
        tick();
        chk("resume_idle", 64'(grant), 0);
        tick();
        chk("p1_after_tail", 64'(grant), 64'h02);
        chk("p1_data", 64'(data_out), 64'h10);

        // Single-flit packet on port 1.
        do_reset();
        push(1, 1, 32'h55);
        drive();
        tick();
        chk("sf_grant", 64'(grant), 64'h02);
        chk("sf_rd", 64'(fifo_rd), 64'h02);
        chk("sf_data", 64'(data_out), 64'h55);
        tick();
        chk("sf_idle_grant", 64'(grant), 0);
        chk("sf_idle_busy", 64'(busy), 0);

        // Request without head is never granted.
        do_reset();
        q[0].push_back({1'b0, 1'b1, 32'h77});
        drive();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("nohead_grant", 64'(grant), 0);
        end
        q[0].delete();
        drive();

        // Asynchronous reset mid-packet on port 3.
        lock_on(3, 32'h30);
        rdy_mode = 1;
        drive();
        #1;
        chk("pre_rst_rd", 64'(fifo_rd), 64'h08);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_grant", 64'(grant), 0);
        chk("arst_rd", 64'(fifo_rd), 0);
        chk("arst_busy", 64'(busy), 0);
        q[3].delete();
        push(3, 4, 32'h38);
        push(0, 1, 32'h01);
        drive();
        tick();
        rst = 1'b1;
        tick();
        chk("arst_winner", 64'(grant), 64'h01);

`ifdef ARB_TIMEOUT_EN
        lock_on(4, 32'h40);
        repeat (7) tick();
        chk("to_early", 64'(timeout_err), 0);
        tick();
        chk("to_set", 64'(timeout_err), 1);
        rdy_mode = 1;
        drive();
        repeat (4) tick();
        chk("to_sticky", 64'(timeout_err), 1);
        do_reset();
        chk("to_clear", 64'(timeout_err), 0);
`endif

        // Random traffic with random back-pressure and request gaps.
        do_reset();
        rdy_mode = 2;
        gap_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            int p;
            p = $urandom_range(0, N - 1);
            if ($urandom_range(0, 3) == 0 && q[p].size() < 8) push(p, $urandom_range(1, 4), $urandom);
            tick();
        end
        rdy_mode = 1;
        gap_en = 1'b0;
        t = 0;
        while (t < 500 && (q[0].size() + q[1].size() + q[2].size() + q[3].size() + q[4].size()) != 0) begin
            tick();
            t++;
        end
        chk("drain_done", 64'(q[0].size() + q[1].size() + q[2].size() + q[3].size() + q[4].size()), 0);
        tick();
        chk("drain_idle", 64'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
